// File: rtl/uart_rx_os_if.sv
// Receive-side byte handshake of the oversampling UART: holding register,
// its valid/ack pair, and the framing and overrun status flags.
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ack;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data_out,
    output data_valid,
    output frame_err,
    output overrun,
    input  data_ack
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  overrun,
    output data_ack
  );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver: two-flop line synchronizer, mid-bit sampling
// FSM, and a valid/ack holding register with framing-error and overrun flags.
module uart_rx_os #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          rx_in,
  output logic          busy,
  uart_rx_os_if.master  rx_if
);

  localparam int H     = OVERSAMPLE / 2;
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  generate
    if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_os
      $error("uart_rx_os: OVERSAMPLE must be even and at least 4");
    end
    if (DATA_BITS < 2) begin : g_bad_db
      $error("uart_rx_os: DATA_BITS must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_e;

  logic                 sync1_q;
  logic                 rx_s_q;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic                 load;
  logic                 ferr_set;
  logic                 ack_ok;

  // Line idles high, so the synchronizer presets to 1 to avoid a false start.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    load     = 1'b0;
    ferr_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = START;
        end
      end

      START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            load    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // A load and an ack on the same edge: the new byte wins and no overrun is flagged.
  always_comb begin
    ack_ok  = rx_if.data_ack && valid_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (load) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ferr_d  = 1'b0;
    end else if (ack_ok) begin
      valid_d = 1'b0;
    end

    if (ferr_set) begin
      ferr_d = 1'b1;
    end

    if (load && valid_q && !rx_if.data_ack) begin
      ovr_d = 1'b1;
    end else if (ack_ok) begin
      ovr_d = 1'b0;
    end
  end

  assign busy             = (state_q != IDLE);
  assign rx_if.data_out   = data_q;
  assign rx_if.data_valid = valid_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: expected bytes are queued when frames are sent
// and a monitor pops them whenever the receiver presents a new byte.
module tb_uart_rx_os;

  logic clk;
  logic rst_n;
  logic rx;
  logic busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb[$];

  uart_rx_os_if #(.DATA_BITS(8)) bus ();

  uart_rx_os #(
    .OVERSAMPLE(8),
    .DATA_BITS (8)
  ) dut (
    .clk_in(clk),
    .rst_n (rst_n),
    .rx_in (rx),
    .busy  (busy),
    .rx_if (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; each bit lasts 8 clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (8) @(negedge clk);
    end
    rx = stop;
    repeat (8) @(negedge clk);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
  endtask

  // Monitor: a new byte shows as a valid rise or a data change while valid.
  logic       mon_pv = 1'b0;
  logic [7:0] mon_pd = 8'h00;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mon_pv = 1'b0;
      mon_pd = 8'h00;
    end else begin
      if (bus.data_valid && (!mon_pv || bus.data_out != mon_pd)) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_byte actual=%0h expected=none", bus.data_out);
        end else begin
          logic [7:0] exp_b;
          exp_b = sb.pop_front();
          chk("sb_data", {24'h0, bus.data_out}, {24'h0, exp_b});
          chk("sb_frame_err", {31'h0, bus.frame_err}, 32'h0);
        end
      end
      mon_pv = bus.data_valid;
      mon_pd = bus.data_out;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    rx           = 1'b1;
    bus.data_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, bus.data_valid}, 32'h0);
    chk("rst_data", {24'h0, bus.data_out}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_flags", {30'h0, bus.frame_err, bus.overrun}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 0xA5 with exact latency: valid rises and busy falls at E78.
    sb.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (78) @(posedge clk);
        #1;
        chk("a5_valid_e77", {31'h0, bus.data_valid}, 32'h0);
        chk("a5_busy_e77", {31'h0, busy}, 32'h1);
        @(posedge clk);
        #1;
        chk("a5_valid_e78", {31'h0, bus.data_valid}, 32'h1);
        chk("a5_busy_e78", {31'h0, busy}, 32'h0);
        chk("a5_data_e78", {24'h0, bus.data_out}, 32'hA5);
      end
    join
    @(negedge clk);
    bus.data_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("a5_ack_clears", {31'h0, bus.data_valid}, 32'h0);
    @(negedge clk);
    bus.data_ack = 1'b0;
    repeat (4) @(negedge clk);

    // Start glitch: two low clocks, rejected at the START midpoint.
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("glitch_busy_mid", {31'h0, busy}, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    chk("glitch_idle", {31'h0, busy}, 32'h0);
    chk("glitch_no_valid", {31'h0, bus.data_valid}, 32'h0);
    repeat (4) @(negedge clk);

    // Framing error with a held break, then a clean frame clears it.
    send_frame(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr_set", {31'h0, bus.frame_err}, 32'h1);
    chk("ferr_valid_kept", {31'h0, bus.data_valid}, 32'h0);
    chk("ferr_busy_break", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("ferr_busy_release", {31'h0, busy}, 32'h0);
    chk("ferr_sticky", {31'h0, bus.frame_err}, 32'h1);
    @(negedge clk);
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    chk("ferr_clear_data", {24'h0, bus.data_out}, 32'h81);
    chk("ferr_cleared", {31'h0, bus.frame_err}, 32'h0);
    ack_pulse();

    // Back-to-back without ack: overrun.
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    chk("ovr_data", {24'h0, bus.data_out}, 32'h22);
    chk("ovr_valid", {31'h0, bus.data_valid}, 32'h1);
    chk("ovr_flag", {31'h0, bus.overrun}, 32'h1);
    @(negedge clk);
    bus.data_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_ack_valid", {31'h0, bus.data_valid}, 32'h0);
    chk("ovr_ack_flag", {31'h0, bus.overrun}, 32'h0);
    @(negedge clk);
    bus.data_ack = 1'b0;

    // Ack on the very load edge: new byte wins, no overrun.
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    sb.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (78) @(negedge clk);
        bus.data_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("ackload_valid", {31'h0, bus.data_valid}, 32'h1);
        chk("ackload_data", {24'h0, bus.data_out}, 32'h22);
        chk("ackload_no_ovr", {31'h0, bus.overrun}, 32'h0);
        @(negedge clk);
        bus.data_ack = 1'b0;
      end
    join

    // Overrun again so the reset test drops every flag.
    sb.push_back(8'h33);
    send_frame(8'h33, 1'b1);
    chk("pre_rst_ovr", {31'h0, bus.overrun}, 32'h1);

    // Asynchronous reset during bit 4 of 0xFF.
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (44) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'h0, busy}, 32'h0);
        chk("async_rst_valid", {31'h0, bus.data_valid}, 32'h0);
        chk("async_rst_data", {24'h0, bus.data_out}, 32'h0);
        chk("async_rst_flags", {30'h0, bus.frame_err, bus.overrun}, 32'h0);
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    chk("post_rst_data", {24'h0, bus.data_out}, 32'h5A);
    chk("post_rst_valid", {31'h0, bus.data_valid}, 32'h1);
    chk("post_rst_flags", {30'h0, bus.frame_err, bus.overrun}, 32'h0);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Oversampling UART receiver, one per channel in the 256-UART array.
- Sits directly downstream of the 250:1 clock divider and runs on its divided clock (nominally 1 MHz); each clock is one oversample tick.
- Recovers 8N1 frames from a serial line and presents bytes through a valid/ack holding register, with framing-error and overrun flags.
- Baud rate = f(clk_in) / OVERSAMPLE (125 kbaud at the default).

Parameters:
- OVERSAMPLE, 8, clock ticks per bit; must be even and at least 4.
- DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
- clk_in  input  1  oversample clock from the divider; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_in  input  1  asynchronous serial line, idle high.
- data_out  output  DATA_BITS  last correctly framed byte.
- data_valid  output  1  data_out holds an unconsumed byte.
- data_ack  input  1  consumer acknowledge, sampled on clk_in.
- frame_err  output  1  last frame had stop bit = 0.
- overrun  output  1  a byte was overwritten before it was acknowledged.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: the two-flop rx_in synchronizer presets to 1. State = IDLE, counters = 0, data_out = 0. data_valid, frame_err and overrun = 0. busy = 0.
- Reset mid-frame aborts the frame immediately. Nothing is loaded and no flag is set.
- The synchronized line is rx_s; the FSM sees rx_in only through rx_s.
- Let H = OVERSAMPLE/2 and cnt = the tick counter, sized by clog2(OVERSAMPLE).
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: if rx_s = 0, go to START with cnt = 0.
  - START: increment cnt. At the edge where cnt = H-1, sample rx_s.
    - rx_s = 0: go to DATA with cnt = 0 and bit index = 0.
    - rx_s = 1: glitch; return to IDLE with no output.
  - DATA: increment cnt, wrapping at OVERSAMPLE-1. At cnt = OVERSAMPLE-1, shift rx_s into the MSB of the shift register (right shift). After DATA_BITS samples, go to STOP with cnt = 0.
  - STOP: at cnt = OVERSAMPLE-1, sample rx_s.
    - rx_s = 1: load data_out from the shift register, set data_valid, clear frame_err, go to IDLE.
    - rx_s = 0: set frame_err, leave data_out and data_valid untouched, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s = 1, then go to IDLE. This covers break conditions.
- Timing: edge E0 is the first clk_in edge that captures rx_in = 0.
  - IDLE detects the start bit at E2.
  - The start bit is validated at E2+H.
  - Data bit k is sampled at E2+H+(k+1)·OVERSAMPLE.
  - Stop is sampled at E2+H+(DATA_BITS+1)·OVERSAMPLE.
  - data_valid is high immediately after that edge: E78 at the defaults.
- Back-to-back frames: a start bit immediately following the stop sample is detected with no lost ticks, because the next falling edge is seen from IDLE.
- Handshake:
  - data_ack while data_valid = 1 clears data_valid on the same edge.
  - data_ack while data_valid = 0 is ignored.
  - data_valid stays high until acked; data_out is stable while data_valid = 1, except on overrun.
- Load while data_valid = 1 and no ack in that cycle: data_out takes the new byte, data_valid stays 1, overrun is set.
- Load and ack in the same cycle: the load wins. data_valid stays 1, data_out takes the new byte, and overrun is not set.
- overrun is sticky and clears only on an accepted data_ack, unless that same edge sets it again.
- frame_err stays set until the next correctly framed byte.

Test Plan:
- Send 0xA5 at the defaults (8 ticks/bit): data_valid rises after E78 with data_out = 0xA5, frame_err = 0, and busy drops at the same edge. Pulse data_ack → data_valid = 0 on the next edge.
- rx_in low for 2 clocks, then high: START sees 1 at its mid-point → back to IDLE, no data_valid, state IDLE within 6 clocks.
- Send 0x3C with stop bit = 0, holding the line low 20 more clocks: frame_err = 1, data_valid unchanged, busy stays high until rx_s returns to 1. Then send 0x81 correctly → data_out = 0x81, frame_err = 0.
- Send 0x11 then 0x22 back-to-back with no ack: data_out = 0x22, data_valid = 1, overrun = 1. Then ack → data_valid = 0, overrun = 0.
- Send 0x11 (unacked), then 0x22 with data_ack asserted exactly on the 0x22 load edge: data_out = 0x22, data_valid = 1, overrun = 0.
- Assert rst_n = 0 asynchronously during bit 4 of 0xFF: all outputs drop to their reset values with no clock. Release, then send 0x5A → 0x5A received cleanly.
